// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage feeding a 2-entry valid/ready output buffer
module fifo_stream_reader #(
    parameter int B       = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [B-1:0]     fifo_r_data,
    input  logic             fifo_valid,
    output logic             fifo_rd,
    output logic [B-1:0]     m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_count,
    output logic             err_underflow
);
    localparam int             PIW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PIW-1:0] LAST_IDX = PIW'(PKT_LEN - 1);

    logic [1:0]       r_occ;
    logic [B-1:0]     r_data0;
    logic [B-1:0]     r_data1;
    logic             r_last0;
    logic             r_last1;
    logic [PIW-1:0]   r_pkt_idx;
    logic [CNT_W-1:0] r_beat_count;
    logic             r_err;

    logic w_cap;
    logic w_pop;
    logic w_new_last;

    // Read request looks only at registered occupancy so m_ready never reaches fifo_rd.
    assign w_cap      = en & ~fifo_empty & (r_occ != 2'd2);
    assign w_pop      = (r_occ != 2'd0) & m_ready;
    assign w_new_last = (r_pkt_idx == LAST_IDX);

    assign fifo_rd       = w_cap;
    assign m_valid       = (r_occ != 2'd0);
    assign m_data        = r_data0;
    assign m_last        = r_last0;
    assign beat_count    = r_beat_count;
    assign err_underflow = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ        <= 2'd0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_last0      <= 1'b0;
            r_last1      <= 1'b0;
            r_pkt_idx    <= '0;
            r_beat_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_cap) begin
                r_pkt_idx <= (r_pkt_idx == LAST_IDX) ? '0 : r_pkt_idx + 1'b1;
            end
            if (w_pop) begin
                r_beat_count <= r_beat_count + 1'b1;
            end
            if (w_cap & ~fifo_valid) begin
                r_err <= 1'b1;
            end
            // Slot 0 is the head; simultaneous capture and pop only happens at occ=1.
            case ({w_cap, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= fifo_r_data;
                        r_last0 <= w_new_last;
                    end else begin
                        r_data1 <= fifo_r_data;
                        r_last1 <= w_new_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    r_data0 <= fifo_r_data;
                    r_last0 <= w_new_last;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - queue-model bench for fifo_stream_reader
module tb_fifo_stream_reader;
    localparam int PKT_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_r_data;
    logic        fifo_valid;
    logic        fifo_rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] beat_count;
    logic        err_underflow;
    logic        force_uf;

    fifo_stream_reader #(.B(8), .PKT_LEN(PKT_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data), .fifo_valid(fifo_valid), .fifo_rd(fifo_rd),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .beat_count(beat_count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    assign fifo_valid = fifo_rd & ~fifo_empty & ~force_uf;

    logic [7:0] q[$];
    logic [8:0] mb[$];
    logic [8:0] dlog[$];
    int         pkt;
    int         beats;
    logic       err;
    int         rd_pulses;
    int         checks;
    int         errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty  = (q.size() == 0);
        fifo_r_data = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic model_reset();
        mb.delete();
        pkt   = 0;
        beats = 0;
        err   = 1'b0;
    endtask

    task automatic step();
        logic       exp_rd;
        logic       pop;
        logic       vld;
        logic [7:0] head;
        #1;
        exp_rd = en && (q.size() != 0) && (mb.size() != 2);
        chk("fifo_rd", fifo_rd, exp_rd);
        chk("m_valid", m_valid, mb.size() != 0);
        if (mb.size() != 0) begin
            chk("m_data", m_data, mb[0][7:0]);
            chk("m_last", m_last, mb[0][8]);
        end
        chk("beat_count", beat_count, beats);
        chk("err_underflow", err_underflow, err);
        if (fifo_rd) rd_pulses++;
        pop  = (mb.size() != 0) && m_ready;
        vld  = fifo_valid;
        head = (q.size() != 0) ? q[0] : 8'h00;
        @(posedge clk);
        #1;
        if (pop) begin
            dlog.push_back(mb[0]);
            void'(mb.pop_front());
            beats = (beats + 1) % 65536;
        end
        if (exp_rd) begin
            mb.push_back({(pkt == PKT_LEN - 1), head});
            pkt = (pkt + 1) % PKT_LEN;
            if (vld) void'(q.pop_front());
            else err = 1'b1;
        end
        drive_fifo();
    endtask

    initial begin
        checks = 0; errors = 0; rd_pulses = 0;
        reset = 1'b1; en = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
        model_reset();
        drive_fifo();
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_beat_count", beat_count, 0);
        chk("rst_err", err_underflow, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: fill to occ=2 mid-packet, then reset asynchronously
        en = 1'b1;
        for (int i = 0; i < 5; i++) q.push_back(8'h30 + 8'(i));
        drive_fifo();
        repeat (3) step();
        #2;
        q.delete();
        drive_fifo();
        reset = 1'b1;
        #1;
        chk("t1_m_valid", m_valid, 0);
        chk("t1_fifo_rd", fifo_rd, 0);
        chk("t1_beat_count", beat_count, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(8'h40 + 8'(i));
        drive_fifo();
        m_ready = 1'b1;
        dlog.delete();
        repeat (7) step();
        chk("t1_count", dlog.size(), 4);
        if (dlog.size() == 4) begin
            chk("t1_first_last", dlog[0][8], 0);
            chk("t1_fourth_last", dlog[3], 9'h143);
        end

        // 2: preloaded 0x01..0x08 at full throughput
        reset = 1'b1; #1; model_reset(); @(posedge clk); #1; reset = 1'b0;
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        drive_fifo();
        dlog.delete();
        repeat (10) step();
        chk("t2_beats", beat_count, 8);
        chk("t2_count", dlog.size(), 8);
        for (int i = 0; i < dlog.size(); i++)
            chk("t2_word", dlog[i], {((i % 4) == 3), 8'(i + 1)});

        // 3: backpressure with buffer full
        m_ready = 1'b0;
        dlog.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'h10 + 8'(i));
        drive_fifo();
        repeat (4) step();
        #1;
        chk("t3_fifo_rd", fifo_rd, 0);
        chk("t3_fifo_empty", fifo_empty, 0);
        chk("t3_m_data", m_data, 8'h10);
        m_ready = 1'b1;
        repeat (10) step();
        chk("t3_count", dlog.size(), 6);
        for (int i = 0; i < dlog.size(); i++)
            chk("t3_order", dlog[i][7:0], 8'h10 + 8'(i));

        // 4: single word on an empty FIFO
        repeat (2) step();
        rd_pulses = 0;
        q.push_back(8'hAA);
        drive_fifo();
        repeat (4) step();
        chk("t4_rd_pulses", rd_pulses, 1);
        chk("t4_m_valid", m_valid, 0);

        // 5: en=0 drains held word without new reads
        m_ready = 1'b0;
        q.push_back(8'h50);
        drive_fifo();
        step();
        for (int i = 1; i < 4; i++) q.push_back(8'h50 + 8'(i));
        drive_fifo();
        en = 1'b0;
        rd_pulses = 0;
        repeat (2) step();
        m_ready = 1'b1;
        repeat (2) step();
        chk("t5_no_reads", rd_pulses, 0);
        chk("t5_m_valid", m_valid, 0);
        en = 1'b1;
        repeat (6) step();

        // 6: underflow is sticky until reset
        q.push_back(8'h66); q.push_back(8'h67);
        drive_fifo();
        force_uf = 1'b1;
        step();
        force_uf = 1'b0;
        repeat (5) step();
        chk("t6_err_sticky", err_underflow, 1);
        reset = 1'b1; #1;
        chk("t6_err_reset", err_underflow, 0);
        model_reset();
        q.delete(); drive_fifo();
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) != 0 && q.size() < 8) q.push_back(8'($urandom));
            drive_fifo();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
